// File: rtl/fractional_tick_gen_pkg.sv
// Shared types and sizing helpers for the fractional tick generator.
// Every file in this slice imports it.
package fractional_tick_gen_pkg;

  // Width of the configuration channel index; covers up to 8 channels.
  localparam int CH_IDX_W = 3;

  typedef enum logic [1:0] {
    CH_DISABLED = 2'd0,
    CH_SETTLING = 2'd1,
    CH_LOCKED   = 2'd2
  } ch_state_e;

  // Bits needed for a settle counter that can hold 0..settle_ticks.
  function automatic int settle_cnt_w(input int settle_ticks);
    return $clog2(settle_ticks + 1);
  endfunction

endpackage

// File: rtl/tick_nco_channel.sv
// One NCO channel: phase accumulator, carry-out tick, settle counter and lock state.
// Reprogramming keeps the phase; sync zeroes it; ticks are counted only while settling.
module tick_nco_channel
  import fractional_tick_gen_pkg::*;
#(
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] DEF_INC      = '1,
  parameter int               SETTLE_TICKS = 16
) (
  input  logic             i_refclk,
  input  logic             i_rst,
  input  logic             i_apply,
  input  logic [ACC_W-1:0] i_inc,
  input  logic             i_sync,
  output logic             o_tick,
  output logic             o_clk_sq,
  output logic             o_locked
);

  localparam int               CNT_W    = settle_cnt_w(SETTLE_TICKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_TICKS - 1);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic             r_tick;
  logic             r_locked;
  logic [CNT_W-1:0] r_cnt;
  ch_state_e        r_state;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_inc    <= DEF_INC;
      r_tick   <= 1'b0;
      r_locked <= 1'b0;
      r_cnt    <= '0;
      r_state  <= CH_SETTLING;
    end else begin
      // The apply cycle holds the phase so the new increment starts from where the old one left off.
      if (i_sync) begin
        r_acc  <= '0;
        r_tick <= 1'b0;
      end else if (i_apply) begin
        r_tick <= 1'b0;
      end else begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_tick <= w_sum[ACC_W];
      end

      if (i_apply) begin
        r_inc    <= i_inc;
        r_cnt    <= '0;
        r_locked <= 1'b0;
        r_state  <= (i_inc == '0) ? CH_DISABLED : CH_SETTLING;
      end else begin
        case (r_state)
          CH_SETTLING: begin
            if (r_tick) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == LAST_CNT) begin
                r_state  <= CH_LOCKED;
                r_locked <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_tick   = r_tick;
  assign o_clk_sq = r_acc[ACC_W-1];
  assign o_locked = r_locked;

endmodule

// File: rtl/fractional_tick_gen.sv
// Multi-channel fractional tick generator: single-entry config handshake plus sync fan-out.
// A write is captured, applied the following cycle, and blocks further writes for that one cycle.
module fractional_tick_gen
  import fractional_tick_gen_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          ACC_W        = 32,
  parameter int unsigned DEF_INC      = 153744281,
  parameter int          SETTLE_TICKS = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  output logic                cfg_err,
  input  logic                sync,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   clk_sq,
  output logic [NUM_CH-1:0]   locked
);

  localparam logic [ACC_W-1:0]  W_DEF_INC = ACC_W'(DEF_INC);
  localparam logic [CH_IDX_W:0] NUM_CH_L  = (CH_IDX_W + 1)'(NUM_CH);

  logic                r_pend_vld;
  logic [CH_IDX_W-1:0] r_pend_ch;
  logic [ACC_W-1:0]    r_pend_inc;
  logic                w_xfer;
  logic                w_bad_ch;
  logic [NUM_CH-1:0]   w_apply;

  // The pending slot doubles as the busy flag, so ready drops exactly during the apply cycle.
  assign cfg_ready = !rst && !r_pend_vld;
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_bad_ch  = {1'b0, r_pend_ch} >= NUM_CH_L;
  assign cfg_err   = !rst && r_pend_vld && w_bad_ch;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_ch  <= '0;
      r_pend_inc <= '0;
    end else begin
      r_pend_vld <= w_xfer;
      if (w_xfer) begin
        r_pend_ch  <= cfg_ch;
        r_pend_inc <= cfg_inc;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_apply[g] = r_pend_vld && (r_pend_ch == CH_IDX_W'(g));

    tick_nco_channel #(
      .ACC_W        (ACC_W),
      .DEF_INC      (W_DEF_INC),
      .SETTLE_TICKS (SETTLE_TICKS)
    ) u_ch (
      .i_refclk (refclk),
      .i_rst    (rst),
      .i_apply  (w_apply[g]),
      .i_inc    (r_pend_inc),
      .i_sync   (sync),
      .o_tick   (tick[g]),
      .o_clk_sq (clk_sq[g]),
      .o_locked (locked[g])
    );
  end

endmodule

// File: tb/tb_fractional_tick_gen.sv
// Bench for fractional_tick_gen: config table, directed corner sequences, random run vs. phase model.
module tb_fractional_tick_gen;

  localparam int NUM_CH  = 2;
  localparam int ACC_W   = 8;
  localparam int DEF_INC = 37;
  localparam int SETTLE  = 16;
  localparam int MOD     = 256;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic              cfg_err;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_sq;
  logic [NUM_CH-1:0] locked;

  always #5 refclk = ~refclk;

  fractional_tick_gen #(
    .NUM_CH       (NUM_CH),
    .ACC_W        (ACC_W),
    .DEF_INC      (DEF_INC),
    .SETTLE_TICKS (SETTLE)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_err   (cfg_err),
    .sync      (sync),
    .tick      (tick),
    .clk_sq    (clk_sq),
    .locked    (locked)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase as a plain integer, lock as "ticks seen since last program >= SETTLE".
  int m_acc  [NUM_CH];
  int m_inc  [NUM_CH];
  int m_seen [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_lock [NUM_CH];
  bit m_busy;
  int m_pch;
  int m_pinc;

  logic [NUM_CH-1:0] s_tick, s_clk, s_locked;
  logic              s_ready, s_err;

  typedef struct {
    bit       rst;
    bit       valid;
    bit [2:0] ch;
    bit [7:0] inc;
    bit       sync;
    bit       exp_ready;
    bit       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c]  = 0;
      m_inc[c]  = DEF_INC;
      m_seen[c] = 0;
      m_tick[c] = 0;
      m_lock[c] = 0;
    end
    m_busy = 0;
    m_pch  = 0;
    m_pinc = 0;
  endtask

  task automatic model_step();
    bit xfer;
    bit prog;
    int p;
    xfer = cfg_valid && !rst && !m_busy;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        prog = m_busy && (m_pch == c);
        if (!prog && m_tick[c]) m_seen[c]++;
        if (sync) begin
          m_acc[c]  = 0;
          m_tick[c] = 0;
        end else if (prog) begin
          m_tick[c] = 0;
        end else begin
          p         = m_acc[c] + m_inc[c];
          m_tick[c] = (p >= MOD);
          m_acc[c]  = p % MOD;
        end
        if (prog) begin
          m_inc[c]  = m_pinc;
          m_seen[c] = 0;
        end
        m_lock[c] = (m_inc[c] != 0) && (m_seen[c] >= SETTLE);
      end
      m_busy = xfer;
      if (xfer) begin
        m_pch  = int'(cfg_ch);
        m_pinc = int'(cfg_inc);
      end
    end
  endtask

  // One clock: compare every output against the model mid-cycle, advance the model, step past the edge.
  task automatic cycle();
    @(negedge refclk);
    s_tick   = tick;
    s_clk    = clk_sq;
    s_locked = locked;
    s_ready  = cfg_ready;
    s_err    = cfg_err;
    chk("cfg_ready", 32'(s_ready), 32'(!rst && !m_busy));
    chk("cfg_err", 32'(s_err), 32'(!rst && m_busy && (m_pch >= NUM_CH)));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("tick[%0d]", c), 32'(s_tick[c]), 32'(m_tick[c]));
      chk($sformatf("clk_sq[%0d]", c), 32'(s_clk[c]), 32'(m_acc[c] >= MOD / 2));
      chk($sformatf("locked[%0d]", c), 32'(s_locked[c]), 32'(m_lock[c]));
    end
    model_step();
    @(posedge refclk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input int inc);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_inc   = 8'(inc);
    cycle();
    chk("write_accepted", 32'(s_ready), 32'd1);
    cfg_valid = 1'b0;
  endtask

  // Starts the cycle after an apply: ticks must be 'gap' apart and lock must follow the SETTLE-th one.
  task automatic settle_check(input int ch, input int gap, input int ncyc);
    int nt   = 0;
    int last = -1;
    int tlast = -1;
    for (int c = 0; c < ncyc; c++) begin
      cycle();
      if (tlast >= 0 && c == tlast + 1)
        chk($sformatf("locked%0d_after_last_tick", ch), 32'(s_locked[ch]), 32'd1);
      if (s_tick[ch]) begin
        nt++;
        if (last >= 0) chk($sformatf("tick%0d_gap", ch), 32'(c - last), 32'(gap));
        last = c;
        if (nt == SETTLE) begin
          tlast = c;
          chk($sformatf("locked%0d_at_last_tick", ch), 32'(s_locked[ch]), 32'd0);
        end
      end
    end
    chk($sformatf("settle%0d_reached", ch), 32'(tlast >= 0), 32'd1);
  endtask

  // Counts ticks of one channel over cycles 1..256 after a cycle in which acc is 0.
  task automatic count_window(input int ch, output int nt);
    nt = 0;
    for (int c = 1; c <= 256; c++) begin
      cycle();
      if (s_tick[ch]) nt++;
    end
  endtask

  vec_t tbl[8];

  initial begin
    int nt;
    int prev_sq;
    int last_rise;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_inc   = '0;
    sync      = 1'b0;

    tbl[0] = '{1, 0, 3'd0, 8'd0,  0, 0, 0};
    tbl[1] = '{0, 1, 3'd5, 8'd9,  0, 1, 0};
    tbl[2] = '{0, 1, 3'd0, 8'd64, 0, 0, 1};
    tbl[3] = '{0, 1, 3'd0, 8'd64, 0, 1, 0};
    tbl[4] = '{0, 1, 3'd1, 8'd32, 0, 0, 0};
    tbl[5] = '{0, 1, 3'd1, 8'd32, 0, 1, 0};
    tbl[6] = '{0, 0, 3'd0, 8'd0,  0, 0, 0};
    tbl[7] = '{0, 0, 3'd0, 8'd0,  0, 1, 0};

    @(posedge refclk);
    #1;
    model_reset();
    cycle();
    chk("reset_tick", 32'(s_tick), 32'd0);
    chk("reset_clk_sq", 32'(s_clk), 32'd0);
    chk("reset_locked", 32'(s_locked), 32'd0);

    // Handshake table: bad channel, back-to-back writes, alternating ready.
    for (int i = 0; i < 8; i++) begin
      rst       = tbl[i].rst;
      cfg_valid = tbl[i].valid;
      cfg_ch    = tbl[i].ch;
      cfg_inc   = tbl[i].inc;
      sync      = tbl[i].sync;
      cycle();
      chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(tbl[i].exp_err));
    end
    cfg_valid = 1'b0;

    // Rewriting a channel restarts settling; inc=64 ticks every 4th cycle.
    write_cfg(0, 64);
    cycle();
    settle_check(0, 4, 80);

    // inc=3 from zero phase: 3 ticks per 256 cycles and an 85/86-cycle square wave.
    write_cfg(0, 3);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    nt = 0;
    prev_sq = 0;
    last_rise = -1;
    for (int c = 0; c < 300; c++) begin
      cycle();
      if (c >= 1 && c <= 256 && s_tick[0]) nt++;
      if (s_clk[0] && prev_sq == 0) begin
        if (last_rise >= 0)
          chk("clk_sq_period_85_86", 32'((c - last_rise) >= 85 && (c - last_rise) <= 86), 32'd1);
        last_rise = c;
      end
      prev_sq = int'(s_clk[0]);
    end
    chk("inc3_ticks_per_256", 32'(nt), 32'd3);

    // Maximum increment: tick on all but one cycle in 256.
    write_cfg(1, 255);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    cycle();
    count_window(1, nt);
    chk("inc255_ticks_per_256", 32'(nt), 32'd255);
    chk("ch1_locked_before_disable", 32'(s_locked[1]), 32'd1);

    // Disable then re-enable channel 1.
    write_cfg(1, 0);
    cycle();
    for (int c = 0; c < 20; c++) begin
      cycle();
      chk("disabled_tick1", 32'(s_tick[1]), 32'd0);
      chk("disabled_locked1", 32'(s_locked[1]), 32'd0);
    end
    write_cfg(1, 32);
    cycle();
    settle_check(1, 8, 150);

    // Sync coinciding with a ch0 apply: both channels restart in phase with equal increments.
    write_cfg(1, 40);
    cycle();
    write_cfg(0, 40);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    for (int c = 0; c < 100; c++) begin
      cycle();
      chk("aligned_tick", 32'(s_tick[0]), 32'(s_tick[1]));
      chk("aligned_clk_sq", 32'(s_clk[0]), 32'(s_clk[1]));
    end

    // Reset landing on the apply cycle of a pending write: write lost, default increment back.
    write_cfg(0, 100);
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_tick", 32'(s_tick), 32'd0);
    chk("rst_clk_sq", 32'(s_clk), 32'd0);
    chk("rst_locked", 32'(s_locked), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    rst = 1'b0;
    cycle();
    chk("ready_after_rst", 32'(s_ready), 32'd1);
    count_window(0, nt);
    chk("def_inc_restored", 32'(nt), 32'(DEF_INC));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
      case ($urandom_range(0, 5))
        0:       cfg_inc = 8'd0;
        1:       cfg_inc = 8'd255;
        2:       cfg_inc = 8'($urandom_range(1, 8));
        default: cfg_inc = 8'($urandom_range(1, 255));
      endcase
      sync = ($urandom_range(0, 49) == 0);
      cycle();
    end

    rst       = 1'b0;
    cfg_valid = 1'b0;
    sync      = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fractional_tick_gen.md
FRACTIONAL_TICK_GEN -- requirements
Module: fractional_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent tick channels (1..8).
REQ-002 Parameter ACC_W, default 32, phase-accumulator and increment width (8..32).
REQ-003 Parameter DEF_INC, default 153744281, reset increment for every channel (1.789819 MHz from 50 MHz at ACC_W=32).
REQ-004 Parameter SETTLE_TICKS, default 16, channel ticks required after reprogramming before locked reasserts (1..255).
REQ-005 refclk  input  1  sole clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 cfg_valid  input  1  a configuration write is offered.
REQ-008 cfg_ready  output  1  the block can accept a configuration write.
REQ-009 cfg_ch  input  3  target channel index.
REQ-010 cfg_inc  input  ACC_W  new increment; 0 disables the channel.
REQ-011 cfg_err  output  1  one-cycle pulse when an accepted write has cfg_ch >= NUM_CH.
REQ-012 sync  input  1  single-cycle request to phase-align all channels.
REQ-013 tick  output  NUM_CH  per-channel one-cycle clock-enable pulse.
REQ-014 clk_sq  output  NUM_CH  per-channel accumulator MSB (approx. 50 % duty square wave).
REQ-015 locked  output  NUM_CH  per-channel "frequency settled" flag.

Function
REQ-016 Per enabled channel, each cycle: sum = acc + inc (ACC_W+1 bits); acc <= sum[ACC_W-1:0]; tick <= sum[ACC_W]; tick frequency = f_refclk * inc / 2^ACC_W.
REQ-017 clk_sq[i] shall equal the registered acc[i][ACC_W-1].
REQ-018 A handshake transfers when cfg_valid && cfg_ready; inputs are captured into a single pending register.
REQ-019 cfg_ready shall be low exactly the one cycle after a transfer and high otherwise (outside reset).
REQ-020 A captured write is applied in the cycle after the transfer: inc[ch] <= cfg_inc; acc[ch] is kept (no phase jump).
REQ-021 A captured write with cfg_ch >= NUM_CH changes no state and pulses cfg_err in its apply cycle.
REQ-022 Channel states: DISABLED (inc=0), SETTLING, LOCKED; locked[i] is high only in LOCKED.
REQ-023 Applying inc != 0 enters SETTLING from any state and clears the channel's settle counter, including when the channel is already SETTLING.
REQ-024 In SETTLING, each tick increments the counter; on the SETTLE_TICKS-th tick, enter LOCKED with locked high from the next cycle.
REQ-025 Applying inc = 0 enters DISABLED: acc held, tick and locked low from the next cycle.
REQ-026 sync clears every acc to 0 in the next cycle and drives tick low in that cycle; inc and state are unchanged.
REQ-027 sync and a config apply in the same cycle: both take effect, so the target channel gets the new inc and acc = 0.
REQ-028 Accumulator wrap is modulo 2^ACC_W; inc = 2^ACC_W-1 ticks on all but one cycle in 2^ACC_W.

Reset
REQ-029 While rst is high: every acc = 0; every inc = DEF_INC; every state = SETTLING with counter 0; tick = 0; clk_sq = 0; locked = 0; cfg_err = 0; cfg_ready = 0; pending write discarded.
REQ-030 cfg_ready shall be high in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-write or mid-settle overrides all other activity in that cycle.

Structure
REQ-032 A shared package holds the channel-state enum, the channel-index width (3), and the SETTLE counter width function.
REQ-033 One sub-module, tick_nco_channel (accumulator, state machine, settle counter), is instantiated NUM_CH times; the top holds the config handshake and sync fan-out.

Verification
REQ-034 ACC_W=8, write ch0 inc=64 -> tick[0] every 4th cycle; locked[0] high the cycle after the 16th tick.
REQ-035 ACC_W=8, inc=3 from acc=0 -> exactly 3 ticks in 256 cycles; clk_sq period 85-86 cycles.
REQ-036 Back-to-back cfg_valid -> cfg_ready low on alternate cycles, every write applied in order; cfg_ch=5 with NUM_CH=2 -> cfg_err pulse, no state change.
REQ-037 Write ch1 inc=0 -> tick[1] and locked[1] low next cycle; rewrite inc=32 -> SETTLING, locked[1] after 16 ticks.
REQ-038 sync in the same cycle as a ch0 apply -> both accs = 0 next cycle; ch0 uses the new inc; the ticks of both channels stay aligned afterwards when the increments are equal.
REQ-039 rst asserted while SETTLING with a pending write -> all outputs at reset values, write lost, DEF_INC restored.
